// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction prefetch queue between imem and decode.
// Issues in-order word requests (bounded in flight), tags them with their PC,
// buffers returned instructions in a FIFO and flushes on a downstream redirect.
module fetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [XLEN-1:0]        imem_addr,
    output logic                   imem_req,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [ILEN-1:0]        imem_rdata,
    input  logic                   redirect_en,
    input  logic [XLEN-1:0]        redirect_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ILEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_step,
    output logic [$clog2(DEPTH):0] queue_count
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
    localparam int unsigned SW  = CW + 1;

    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   q_head, q_tail;
    logic [CW-1:0]   q_count;
    logic [XLEN-1:0] tag_pc  [MAX_OUTST];
    logic [TAW-1:0]  tag_head, tag_tail;
    logic [OW-1:0]   outst, kill;
    logic [SW-1:0]   credits;
    logic [SW-1:0]   inflight;
    logic            has_head, grant, resp, push, pop;

    function automatic logic [TAW-1:0] tag_next(input logic [TAW-1:0] p);
        return (p == TAW'(MAX_OUTST - 1)) ? '0 : p + TAW'(1);
    endfunction

    // Credit check and per-cycle event decode; killed responses still own a credit
    always_comb begin
        inflight = SW'(outst) + SW'(kill);
        credits  = SW'(q_count) + inflight;
        imem_req = rst && !redirect_en && (credits < SW'(DEPTH)) && (inflight < SW'(MAX_OUTST));
        grant    = imem_req && imem_gnt;
        resp     = imem_rvalid && (inflight != '0);
        has_head = (q_count != '0);
        push     = resp && (kill == '0) && !redirect_en;
        pop      = has_head && out_ready && !redirect_en;
    end

    // Head-of-queue outputs, forced to zero while the queue is empty
    always_comb begin
        imem_addr   = pc;
        out_valid   = has_head;
        queue_count = q_count;
        out_instr   = '0;
        out_pc      = '0;
        out_pc_step = '0;
        if (has_head) begin
            out_instr   = q_instr[q_head];
            out_pc      = q_pc[q_head];
            out_pc_step = q_pc[q_head] + XLEN'(4);
        end
    end

    // PC, queue pointers and in-flight accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            q_head   <= '0;
            q_tail   <= '0;
            q_count  <= '0;
            tag_head <= '0;
            tag_tail <= '0;
            outst    <= '0;
            kill     <= '0;
        end else if (redirect_en) begin
            pc      <= {redirect_addr[XLEN-1:2], 2'b00};
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
            // every request still unanswered after this cycle becomes stale
            kill    <= kill + outst - OW'(resp);
            outst   <= '0;
            if (resp) tag_head <= tag_next(tag_head);
        end else begin
            if (grant) begin
                pc       <= pc + XLEN'(4);
                tag_tail <= tag_next(tag_tail);
            end
            if (resp) tag_head <= tag_next(tag_head);
            if (push) q_tail <= q_tail + AW'(1);
            if (pop)  q_head <= q_head + AW'(1);
            q_count <= q_count + CW'(push) - CW'(pop);
            outst   <= outst + OW'(grant) - OW'(resp && (kill == '0));
            kill    <= kill - OW'(resp && (kill != '0));
        end
    end

    // Tag and instruction storage; validity is tracked by the pointers above
    always_ff @(posedge clk) begin
        if (grant) tag_pc[tag_tail] <= pc;
        if (push) begin
            q_instr[q_tail] <= imem_rdata;
            q_pc[q_tail]    <= tag_pc[tag_head];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic for fetch_queue,
// checked every cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [31:0] RST_PC    = 32'h100;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_step;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    // reference model: PC, delivered-instruction queue, in-flight request queue
    logic [31:0] pc_m;
    entry_t      fifo_m[$];
    logic [31:0] infl_pc[$];
    bit          infl_stale[$];

    // output samples from the most recent step
    logic        last_valid;
    logic [31:0] last_pc;
    logic [31:0] last_step;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_step(out_pc_step), .queue_count(queue_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_req();
        return rst && !redirect_en && (fifo_m.size() + infl_pc.size() < DEPTH)
               && (infl_pc.size() < MAX_OUTST);
    endfunction

    function automatic bit have(input bit want);
        return want && (infl_pc.size() > 0);
    endfunction

    task automatic model_reset();
        pc_m = RST_PC;
        fifo_m.delete();
        infl_pc.delete();
        infl_stale.delete();
    endtask

    task automatic check_outputs();
        bit          v;
        entry_t      h;
        logic [31:0] step_exp;
        v = (fifo_m.size() > 0);
        h = v ? fifo_m[0] : '0;
        step_exp = v ? h.pc + 32'd4 : 32'd0;
        check("imem_req", 64'(imem_req), 64'(exp_req()));
        check("imem_addr", 64'(imem_addr), 64'(pc_m));
        check("out_valid", 64'(out_valid), 64'(v));
        check("out_instr", 64'(out_instr), 64'(h.instr));
        check("out_pc", 64'(out_pc), 64'(h.pc));
        check("out_pc_step", 64'(out_pc_step), 64'(step_exp));
        check("queue_count", 64'(queue_count), 64'(fifo_m.size()));
    endtask

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit          req;
        bit          have_resp;
        bit          stale;
        logic [31:0] rpc;
        req       = exp_req();
        have_resp = imem_rvalid && (infl_pc.size() > 0);
        stale     = 1'b0;
        rpc       = '0;
        if (have_resp) begin
            rpc   = infl_pc.pop_front();
            stale = infl_stale.pop_front();
        end
        if (redirect_en) begin
            fifo_m.delete();
            foreach (infl_stale[i]) infl_stale[i] = 1'b1;
            pc_m = {redirect_addr[31:2], 2'b00};
        end else begin
            if (fifo_m.size() > 0 && out_ready) void'(fifo_m.pop_front());
            if (have_resp && !stale) fifo_m.push_back('{instr: imem_rdata, pc: rpc});
            if (req && imem_gnt) begin
                infl_pc.push_back(pc_m);
                infl_stale.push_back(1'b0);
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    // called at a falling edge: drive, check, clock, update model
    task automatic step(input bit rv, input bit gnt, input bit rdy,
                        input bit red, input logic [31:0] raddr);
        imem_rvalid   = rv;
        imem_rdata    = $urandom;
        imem_gnt      = gnt;
        out_ready     = rdy;
        redirect_en   = red;
        redirect_addr = raddr;
        #1;
        check_outputs();
        last_valid = out_valid;
        last_pc    = out_pc;
        last_step  = out_pc_step;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        model_reset();
        #1;
        check("rst_imem_req", 64'(imem_req), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_out_pc_step", 64'(out_pc_step), 64'(0));
        check("rst_queue_count", 64'(queue_count), 64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(RST_PC));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // run with full-speed memory until the first instruction is delivered
    task automatic wait_first(input string tag, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(have(1), 1, 1, 0, '0);
            if (last_valid) begin
                seen = 1'b1;
                check(tag, 64'(last_pc), 64'(exp_pc));
            end
        end
        if (!seen) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        logic [31:0] got[$];
        logic [31:0] step_at_fc;

        model_reset();
        @(negedge clk);
        pulse_reset();

        // streaming: first delivery two cycles after the first grant, then one per cycle
        step(have(1), 1, 1, 0, '0);
        step(have(1), 1, 1, 0, '0);
        step(have(1), 1, 1, 0, '0);
        check("stream_pc0", 64'(last_pc), 64'(32'h100));
        check("stream_step0", 64'(last_step), 64'(32'h104));
        step(have(1), 1, 1, 0, '0);
        check("stream_pc1", 64'(last_pc), 64'(32'h104));
        step(have(1), 1, 1, 0, '0);
        check("stream_pc2", 64'(last_pc), 64'(32'h108));

        // stall: queue fills to DEPTH, requests stop, head holds
        pulse_reset();
        for (int i = 0; i < 10; i++) step(have(1), 1, 0, 0, '0);
        #1;
        check("stall_count", 64'(queue_count), 64'(4));
        check("stall_req", 64'(imem_req), 64'(0));
        check("stall_head", 64'(out_pc), 64'(32'h100));
        for (int i = 0; i < 6; i++) step(have(1), 1, 1, 0, '0);

        // redirect with two requests in flight and two entries queued
        pulse_reset();
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(have(1), 1, 0, 0, '0);
        step(have(1), 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        check("pre_redirect_count", 64'(queue_count), 64'(2));
        step(0, 1, 1, 1, 32'h2003);
        check("post_redirect_valid", 64'(out_valid), 64'(0));
        check("post_redirect_addr", 64'(imem_addr), 64'(32'h2000));
        wait_first("redirect_first_pc", 32'h2000);

        // redirect coinciding with a response and a pop
        for (int i = 0; i < 4; i++) step(have(1), 1, 1, 0, '0);
        step(have(1), 1, 1, 1, 32'h3000);
        check("redirect_pop_count", 64'(queue_count), 64'(0));
        wait_first("redirect_pop_first_pc", 32'h3000);

        // PC wrap across the top of the address space
        step(0, 1, 1, 1, 32'hFFFF_FFF8);
        step_at_fc = '1;
        for (int i = 0; i < 30 && got.size() < 3; i++) begin
            step(have(1), 1, 1, 0, '0);
            if (last_valid) begin
                got.push_back(last_pc);
                if (last_pc == 32'hFFFF_FFFC) step_at_fc = last_step;
            end
        end
        while (got.size() < 3) got.push_back('1);
        check("wrap_pc0", 64'(got[0]), 64'(32'hFFFF_FFF8));
        check("wrap_pc1", 64'(got[1]), 64'(32'hFFFF_FFFC));
        check("wrap_pc2", 64'(got[2]), 64'(32'h0));
        check("wrap_step", 64'(step_at_fc), 64'(32'h0));

        // reset mid-stream with two requests in flight; late responses ignored
        pulse_reset();
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        pulse_reset();
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        check("late_resp_count", 64'(queue_count), 64'(0));
        wait_first("restart_pc", RST_PC);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step(have($urandom_range(0, 2) != 0), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
